// File: rtl/fdiv.sv
// fdiv: iterative IEEE-754 single-precision divider, y = x1 / x2.
// Radix-2 restoring mantissa division, one quotient bit per cycle.
// Denormals flush to zero and the result is truncated toward zero.
// Fixed latency: done pulses in the cycle after the 27th rising edge
// that follows the accepting edge.
module fdiv (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        ready,
    output logic        done,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operation context captured on the accepting edge
    logic               sgn;
    logic [23:0]        m2;
    logic signed [9:0]  e;
    logic               spec;
    logic [31:0]        spec_val;

    // Iteration state
    logic [25:0]        rem;
    logic [24:0]        q;
    logic [4:0]         cnt;
    logic               norm_ph;
    logic [31:0]        res;

    // Operand classification (raw exponent field 0 = zero, 255 = inf/NaN)
    logic               x1_zero;
    logic               x1_inf;
    logic               x1_nan;
    logic               x2_zero;
    logic               x2_inf;
    logic               x2_nan;
    logic               s_in;
    logic               spec_hit;
    logic [31:0]        spec_res;
    logic signed [9:0]  e_in;

    // Divider step and normalisation
    logic               qbit;
    logic [24:0]        rem_dif;
    logic signed [9:0]  ef;
    logic [22:0]        frac;
    logic [31:0]        norm_res;

    // Classify the incoming operands and pick the special-case result
    always_comb begin
        x1_zero  = (x1[30:23] == 8'h00);
        x1_inf   = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'h0);
        x1_nan   = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'h0);
        x2_zero  = (x2[30:23] == 8'h00);
        x2_inf   = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'h0);
        x2_nan   = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'h0);
        s_in     = x1[31] ^ x2[31];
        e_in     = $signed(10'({2'b00, x1[30:23]}) - 10'({2'b00, x2[30:23]}) + 10'd127);
        spec_hit = 1'b0;
        spec_res = '0;
        if (x1_nan || x2_nan || (x1_zero && x2_zero) || (x1_inf && x2_inf)) begin
            spec_hit = 1'b1;
            spec_res = 32'h7FC0_0000;
        end else if (x1_inf || x2_zero) begin
            spec_hit = 1'b1;
            spec_res = {s_in, 8'hFF, 23'h0};
        end else if (x1_zero || x2_inf) begin
            spec_hit = 1'b1;
            spec_res = {s_in, 31'h0};
        end
    end

    // One restoring-division step on the current remainder
    always_comb begin
        qbit    = (rem >= {2'b00, m2});
        rem_dif = rem[24:0];
        if (qbit) begin
            rem_dif = 25'(rem - {2'b00, m2});
        end
    end

    // Normalise the quotient, then clamp to inf/zero on exponent overflow/underflow
    always_comb begin
        if (q[24]) begin
            frac = q[23:1];
            ef   = e;
        end else begin
            frac = q[22:0];
            ef   = e - 10'sd1;
        end
        if (ef >= 10'sd255) begin
            norm_res = {sgn, 8'hFF, 23'h0};
        end else if (ef <= 10'sd0) begin
            norm_res = {sgn, 31'h0};
        end else begin
            norm_res = {sgn, ef[7:0], frac};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and ready
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (cnt == 5'd24) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (norm_ph) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, iterate, normalise, publish
    // NORM spends two cycles: the first registers the normalised/special
    // result, the second drives y and done; this sets the 27-cycle latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sgn      <= 1'b0;
            m2       <= '0;
            e        <= '0;
            spec     <= 1'b0;
            spec_val <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            norm_ph  <= 1'b0;
            res      <= '0;
            done     <= 1'b0;
            y        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn      <= s_in;
                        m2       <= {1'b1, x2[22:0]};
                        e        <= e_in;
                        spec     <= spec_hit;
                        spec_val <= spec_res;
                        rem      <= {2'b01, x1[22:0]};
                        q        <= '0;
                        cnt      <= '0;
                        norm_ph  <= 1'b0;
                    end
                end
                DIV: begin
                    rem <= {rem_dif, 1'b0};
                    q   <= {q[23:0], qbit};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    if (!norm_ph) begin
                        res     <= spec ? spec_val : norm_res;
                        norm_ph <= 1'b1;
                    end else begin
                        y       <= res;
                        done    <= 1'b1;
                        norm_ph <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: stimulus pushes expected quotient and due
// cycle; an independent monitor pops and compares on every done pulse.
module tb_fdiv;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ready;
    logic        done;
    logic [31:0] y;

    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    int          due_q[$];

    fdiv dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .x1    (x1),
        .x2    (x2),
        .ready (ready),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got y=%h at cycle %0d expected no done", y, cyc);
            end else begin
                logic [31:0] ev;
                int          due;
                ev  = exp_q.pop_front();
                due = due_q.pop_front();
                check("quotient", y, ev);
                check("latency", 32'(cyc), 32'(due));
                check("ready_with_done", {31'h0, ready}, 32'h1);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit push, output int t0);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        t0 = cyc;
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 100 cycles");
        end else begin
            start = 1'b1;
            x1    = a;
            x2    = b;
            @(posedge clk);
            #1;
            t0    = cyc;
            start = 1'b0;
            check("busy_after_accept", {31'h0, ready}, 32'h0);
            if (push) begin
                exp_q.push_back(r);
                due_q.push_back(t0 + 27);
            end
        end
    endtask

    logic [31:0] vec[13][3];

    initial begin
        int t0;
        int k;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        x1       = '0;
        x2       = '0;

        vec = '{
            '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000},  // 6/2
            '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA},  // 1/3 truncated
            '{32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000},  // -7.5/2.5
            '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000},  // x/0
            '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000},  // -0/2
            '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000},  // 0/0
            '{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000},  // -1/inf
            '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000},  // overflow
            '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000},  // underflow
            '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000},  // 1/1
            '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000},  // NaN operand
            '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000},  // inf/inf
            '{32'hFF00_0000, 32'h0080_0000, 32'hFF80_0000}   // negative overflow
        };

        #1;
        check("reset_ready", {31'h0, ready}, 32'h1);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_y", y, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vec[i][0], vec[i][1], vec[i][2], 1'b1, t0);
        end

        // Starts while busy must be ignored
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, t0);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            start = 1'b1;
            x1    = 32'h3F80_0000;
            x2    = 32'h4000_0000;
        end
        @(negedge clk);
        start = 1'b0;
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b1, t0);

        // Reset in the middle of an operation: no done may follow
        issue(32'h40C0_0000, 32'h4000_0000, 32'h0, 1'b0, t0);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midreset_ready", {31'h0, ready}, 32'h1);
        check("midreset_done", {31'h0, done}, 32'h0);
        check("midreset_y", y, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle", {31'h0, ready}, 32'h1);

        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, t0);

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding results expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
